muldiv_sched: RTL and testbench

Execute-stage scheduler for the shared multi-cycle multiply/divide unit of the dual-issue core. The master and slave issue slots each present a mul/div request. The block picks one requester (master priority), runs the iterative divider or the registered multiplier, and holds the E stage with a stall until the HI/LO result is ready. It also aborts cleanly on pipeline flush and holds its result while later stages stall.

---
 rtl/muldiv_sched_pkg.sv | 37 +++
 rtl/muldiv_sched_if.sv | 47 ++++
 rtl/muldiv_sched_div.sv | 78 +++++++
 rtl/muldiv_sched.sv | 168 ++++++++++++++++
 tb/tb_muldiv_sched.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_sched_pkg.sv
// +------------------------------------------------------------------+
// | Module      : muldiv_sched_pkg                                   |
// | Description : Shared types for the execute-stage mul/div         |
// |               scheduler: operation encoding, FSM states and      |
// |               small op-classification helpers.                   |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
`default_nettype none

package muldiv_sched_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_t;

  function automatic logic op_is_mul(input muldiv_op_t op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic op_is_signed(input muldiv_op_t op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_sched_if.sv
// +------------------------------------------------------------------+
// | Module      : muldiv_sched_if                                    |
// | Description : E-stage mul/div request/result bundle.             |
// |               master modport: issue pipeline (drives requests,   |
// |               flush and hold; receives stall and HI/LO result).  |
// |               slave modport : the mul/div scheduler.             |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
`default_nettype none

interface muldiv_sched_if;
  import muldiv_sched_pkg::*;

  logic        E_flush;
  logic        pipe_hold;
  muldiv_op_t  E_master_muldiv_op;
  logic [31:0] E_master_src_a;
  logic [31:0] E_master_src_b;
  muldiv_op_t  E_slave_muldiv_op;
  logic [31:0] E_slave_src_a;
  logic [31:0] E_slave_src_b;
  logic        E_muldiv_stall;
  logic        E_muldiv_valid;
  logic        E_muldiv_slot;
  logic [31:0] E_muldiv_hi;
  logic [31:0] E_muldiv_lo;
  logic        E_muldiv_dual_req;

  modport master (
    output E_flush, pipe_hold,
    output E_master_muldiv_op, E_master_src_a, E_master_src_b,
    output E_slave_muldiv_op, E_slave_src_a, E_slave_src_b,
    input  E_muldiv_stall, E_muldiv_valid, E_muldiv_slot,
    input  E_muldiv_hi, E_muldiv_lo, E_muldiv_dual_req
  );

  modport slave (
    input  E_flush, pipe_hold,
    input  E_master_muldiv_op, E_master_src_a, E_master_src_b,
    input  E_slave_muldiv_op, E_slave_src_a, E_slave_src_b,
    output E_muldiv_stall, E_muldiv_valid, E_muldiv_slot,
    output E_muldiv_hi, E_muldiv_lo, E_muldiv_dual_req
  );

endinterface

`default_nettype wire

// File: rtl/muldiv_sched_div.sv
// +------------------------------------------------------------------+
// | Module      : muldiv_sched_div                                   |
// | Description : Radix-2 restoring divider datapath, one quotient   |
// |               bit per step. Works on magnitudes for signed ops;  |
// |               sign correction is left to the caller.             |
// | Ports       : clk, rst     - clock, sync active-high reset       |
// |               start        - load operands (priority over step)  |
// |               step         - perform one iteration               |
// |               signed_op    - take magnitudes of the operands     |
// |               dividend/divisor - 32-bit operands                 |
// |               quotient/remainder - post-step values (valid after |
// |               the 32nd step, in the same cycle)                  |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
`default_nettype none

module muldiv_sched_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        step,
  input  logic        signed_op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic [32:0] rem_shift;
  logic [31:0] rem_sub;

  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvsr_d = dvsr_q;
    // Quotient register doubles as the dividend shift register.
    rem_shift = {rem_q, quo_q[31]};
    // When the trial subtraction succeeds the true difference is below
    // the divisor, so the low 32 bits are exact.
    rem_sub = rem_shift[31:0] - dvsr_q;
    if (start) begin
      quo_d  = (signed_op && dividend[31]) ? (32'd0 - dividend) : dividend;
      dvsr_d = (signed_op && divisor[31])  ? (32'd0 - divisor)  : divisor;
      rem_d  = '0;
    end else if (step) begin
      if (rem_shift >= {1'b0, dvsr_q}) begin
        rem_d = rem_sub;
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = rem_shift[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvsr_q <= '0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvsr_q <= dvsr_d;
    end
  end

  // Exposing the post-step values lets the scheduler capture the final
  // result in the last iteration cycle without an extra state.
  assign quotient  = quo_d;
  assign remainder = rem_d;

endmodule

`default_nettype wire

// File: rtl/muldiv_sched.sv
// +------------------------------------------------------------------+
// | Module      : muldiv_sched                                       |
// | Description : E-stage scheduler for the shared multi-cycle       |
// |               mul/div unit. Arbitrates master/slave requests     |
// |               (master first), runs the multiplier or divider,    |
// |               stalls IF..E until HI/LO is ready, aborts on flush |
// |               and holds the result under pipe_hold.              |
// | Ports       : clk, rst - clock, sync active-high reset           |
// |               md       - muldiv_sched_if.slave request/result    |
// | Parameters  : MUL_CYCLES - multiplier occupancy (1..32)          |
// |               DIV_CYCLES - divider iterations (32)               |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
`default_nettype none

module muldiv_sched
  import muldiv_sched_pkg::*;
#(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 32
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_sched_if.slave md
);

  localparam logic [4:0] MUL_LOAD = 5'(MUL_CYCLES - 1);
  localparam logic [4:0] DIV_LOAD = 5'(DIV_CYCLES - 1);

  muldiv_state_t state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [32:0]   a_q, a_d;      // operands, extended per op
  logic [32:0]   b_q, b_d;
  logic          slot_q, slot_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic          dual_q, dual_d;

  logic          master_req, slave_req, any_req, accept;
  muldiv_op_t    sel_op;
  logic [31:0]   sel_a, sel_b;
  logic          sel_signed;
  logic [63:0]   product;
  logic [31:0]   div_quo, div_rem;

  always_comb begin
    master_req = (md.E_master_muldiv_op != OP_NONE);
    slave_req  = (md.E_slave_muldiv_op  != OP_NONE);
    any_req    = master_req || slave_req;
    sel_op     = master_req ? md.E_master_muldiv_op : md.E_slave_muldiv_op;
    sel_a      = master_req ? md.E_master_src_a     : md.E_slave_src_a;
    sel_b      = master_req ? md.E_master_src_b     : md.E_slave_src_b;
    sel_signed = op_is_signed(sel_op);
    accept     = (state_q == ST_IDLE) && any_req && !md.E_flush;
  end

  // Low 64 bits of the sign-extended operands give the 33x33 signed product.
  assign product = {{31{a_q[32]}}, a_q} * {{31{b_q[32]}}, b_q};

  muldiv_sched_div u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (accept && !op_is_mul(sel_op)),
    .step      (state_q == ST_DIV),
    .signed_op (sel_signed),
    .dividend  (sel_a),
    .divisor   (sel_b),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    slot_d  = slot_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dual_d  = accept && master_req && slave_req;
    md.E_muldiv_stall = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          md.E_muldiv_stall = 1'b1;
          a_d    = {sel_signed & sel_a[31], sel_a};
          b_d    = {sel_signed & sel_b[31], sel_b};
          slot_d = !master_req;
          if (op_is_mul(sel_op)) begin
            state_d = ST_MUL;
            cnt_d   = MUL_LOAD;
          end else begin
            state_d = ST_DIV;
            cnt_d   = DIV_LOAD;
          end
        end
      end
      ST_MUL: begin
        md.E_muldiv_stall = 1'b1;
        if (cnt_q == 5'd0) begin
          state_d = ST_DONE;
          hi_d    = product[63:32];
          lo_d    = product[31:0];
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      ST_DIV: begin
        md.E_muldiv_stall = 1'b1;
        if (cnt_q == 5'd0) begin
          state_d = ST_DONE;
          // Quotient negated when signs differ; remainder follows dividend.
          lo_d = (a_q[32] ^ b_q[32]) ? (32'd0 - div_quo) : div_quo;
          hi_d = a_q[32] ? (32'd0 - div_rem) : div_rem;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      ST_DONE: begin
        // Requests are ignored here so the finishing op is not relaunched.
        if (!md.pipe_hold) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush wins over everything, including pipe_hold.
    if (md.E_flush) begin
      state_d           = ST_IDLE;
      md.E_muldiv_stall = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      slot_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dual_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      slot_q  <= slot_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dual_q  <= dual_d;
    end
  end

  // Valid comes straight from the state flop; the flush gate keeps a
  // killed instruction from ever seeing its result.
  assign md.E_muldiv_valid    = (state_q == ST_DONE) && !md.E_flush;
  assign md.E_muldiv_slot     = slot_q;
  assign md.E_muldiv_hi       = hi_q;
  assign md.E_muldiv_lo       = lo_q;
  assign md.E_muldiv_dual_req = dual_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sched.sv
// +------------------------------------------------------------------+
// | Module      : tb_muldiv_sched                                    |
// | Description : Scoreboard bench for muldiv_sched. Stimulus pushes |
// |               the expected HI/LO/slot when it issues an op; a    |
// |               monitor pops on each rising valid and checks that  |
// |               the result stays constant while held.              |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
`default_nettype none

module tb_muldiv_sched;
  import muldiv_sched_pkg::*;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  typedef struct {
    logic        slot;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  logic prev_valid = 1'b0;

  muldiv_sched_if md ();

  muldiv_sched #(.MUL_CYCLES(2), .DIV_CYCLES(32)) dut (
    .clk (clk),
    .rst (rst),
    .md  (md)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare on the first valid cycle, then require a stable result.
  always @(negedge clk) begin
    if (md.E_muldiv_valid === 1'b1) begin
      if (prev_valid !== 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid: got valid=1 expected no result (hi=%h lo=%h)",
                   md.E_muldiv_hi, md.E_muldiv_lo);
        end else begin
          cur = sb.pop_front();
          chk("sb_slot", {31'd0, md.E_muldiv_slot}, {31'd0, cur.slot});
          chk("sb_hi", md.E_muldiv_hi, cur.hi);
          chk("sb_lo", md.E_muldiv_lo, cur.lo);
        end
      end else begin
        chk("hold_hi", md.E_muldiv_hi, cur.hi);
        chk("hold_lo", md.E_muldiv_lo, cur.lo);
      end
    end
    prev_valid <= md.E_muldiv_valid;
  end

  task automatic idle_inputs();
    md.E_master_muldiv_op = OP_NONE;
    md.E_master_src_a     = '0;
    md.E_master_src_b     = '0;
    md.E_slave_muldiv_op  = OP_NONE;
    md.E_slave_src_a      = '0;
    md.E_slave_src_b      = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Called just after a posedge; returns at the negedge of the first DONE cycle.
  task automatic run_op(input string name, input logic slot, input muldiv_op_t op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo,
                        input int stall_n, input int dual_n);
    exp_t e;
    int   n    = 0;
    int   dual = 0;
    if (slot) begin
      md.E_slave_muldiv_op = op;
      md.E_slave_src_a     = a;
      md.E_slave_src_b     = b;
    end else begin
      md.E_master_muldiv_op = op;
      md.E_master_src_a     = a;
      md.E_master_src_b     = b;
    end
    e.slot = slot;
    e.hi   = hi;
    e.lo   = lo;
    sb.push_back(e);
    @(negedge clk);
    while (md.E_muldiv_stall === 1'b1 && n < 100) begin
      n++;
      if (md.E_muldiv_dual_req === 1'b1) dual++;
      next_cycle();
      idle_inputs();
      @(negedge clk);
    end
    chk({name, "_stall_cycles"}, n, stall_n);
    chk({name, "_dual_req_cycles"}, dual, dual_n);
    chk({name, "_valid_at_done"}, {31'd0, md.E_muldiv_valid}, 32'd1);
  endtask

  initial begin
    int vcount;
    rst          = 1'b1;
    md.E_flush   = 1'b0;
    md.pipe_hold = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'd0, md.E_muldiv_stall}, 32'd0);
    chk("rst_valid", {31'd0, md.E_muldiv_valid}, 32'd0);
    chk("rst_slot", {31'd0, md.E_muldiv_slot}, 32'd0);
    chk("rst_hi", md.E_muldiv_hi, 32'd0);
    chk("rst_lo", md.E_muldiv_lo, 32'd0);
    chk("rst_dual", {31'd0, md.E_muldiv_dual_req}, 32'd0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // Directed ops, each presented the cycle after the previous DONE exits.
    run_op("multu_m", 1'b0, OP_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 3, 0);
    next_cycle();
    run_op("div_s", 1'b1, OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 0);
    next_cycle();
    run_op("divu_z", 1'b0, OP_DIVU, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF, 33, 0);
    next_cycle();
    run_op("div_z_neg", 1'b0, OP_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'h00000001, 33, 0);
    next_cycle();
    run_op("mult_s", 1'b1, OP_MULT, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 3, 0);
    next_cycle();
    run_op("div_negdiv", 1'b1, OP_DIV, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2, 33, 0);
    next_cycle();

    // Dual request: master MULT wins, slave DIVU must not start.
    md.E_slave_muldiv_op = OP_DIVU;
    md.E_slave_src_a     = 32'd9;
    md.E_slave_src_b     = 32'd2;
    run_op("dual", 1'b0, OP_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 3, 1);
    next_cycle();
    @(negedge clk);
    chk("dual_after_stall", {31'd0, md.E_muldiv_stall}, 32'd0);
    chk("dual_after_valid", {31'd0, md.E_muldiv_valid}, 32'd0);
    next_cycle();

    // pipe_hold in DONE: 4 held cycles with a relaunch bait presented.
    md.pipe_hold = 1'b1;
    run_op("hold", 1'b1, OP_MULTU, 32'h00010000, 32'h00010000, 32'd1, 32'd0, 3, 0);
    for (int k = 1; k < 4; k++) begin
      next_cycle();
      md.E_master_muldiv_op = OP_DIV;
      md.E_master_src_a     = 32'd5;
      md.E_master_src_b     = 32'd1;
      @(negedge clk);
      chk("hold_valid", {31'd0, md.E_muldiv_valid}, 32'd1);
      chk("hold_no_stall", {31'd0, md.E_muldiv_stall}, 32'd0);
    end
    next_cycle();
    md.pipe_hold = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk("hold_drop_valid", {31'd0, md.E_muldiv_valid}, 32'd1);
    next_cycle();
    @(negedge clk);
    chk("hold_exit_valid", {31'd0, md.E_muldiv_valid}, 32'd0);
    chk("hold_exit_stall", {31'd0, md.E_muldiv_stall}, 32'd0);
    next_cycle();

    // Flush at cycle 10 of a DIV, with a fresh request in the flush cycle.
    md.E_master_muldiv_op = OP_DIV;
    md.E_master_src_a     = 32'h1000;
    md.E_master_src_b     = 32'd3;
    @(negedge clk);
    chk("flush_accept_stall", {31'd0, md.E_muldiv_stall}, 32'd1);
    for (int k = 1; k < 10; k++) begin
      next_cycle();
      idle_inputs();
    end
    next_cycle();
    md.E_flush            = 1'b1;
    md.E_master_muldiv_op = OP_MULTU;
    md.E_master_src_a     = 32'd2;
    md.E_master_src_b     = 32'd2;
    @(negedge clk);
    chk("flush_stall", {31'd0, md.E_muldiv_stall}, 32'd0);
    chk("flush_valid", {31'd0, md.E_muldiv_valid}, 32'd0);
    next_cycle();
    md.E_flush = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk("flush_idle_stall", {31'd0, md.E_muldiv_stall}, 32'd0);
    vcount = 0;
    for (int k = 0; k < 40; k++) begin
      if (md.E_muldiv_valid !== 1'b0) vcount++;
      next_cycle();
      @(negedge clk);
    end
    chk("flush_no_valid", vcount, 0);
    next_cycle();

    // Reset in the middle of a MULT.
    md.E_master_muldiv_op = OP_MULT;
    md.E_master_src_a     = 32'd7;
    md.E_master_src_b     = 32'd7;
    @(negedge clk);
    next_cycle();
    idle_inputs();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_stall", {31'd0, md.E_muldiv_stall}, 32'd0);
    chk("mrst_valid", {31'd0, md.E_muldiv_valid}, 32'd0);
    chk("mrst_slot", {31'd0, md.E_muldiv_slot}, 32'd0);
    chk("mrst_hi", md.E_muldiv_hi, 32'd0);
    chk("mrst_lo", md.E_muldiv_lo, 32'd0);
    chk("mrst_dual", {31'd0, md.E_muldiv_dual_req}, 32'd0);
    vcount = 0;
    for (int k = 0; k < 10; k++) begin
      if (md.E_muldiv_valid !== 1'b0) vcount++;
      next_cycle();
      @(negedge clk);
    end
    chk("mrst_no_valid", vcount, 0);
    next_cycle();

    run_op("post_rst", 1'b0, OP_MULTU, 32'd5, 32'd6, 32'd0, 32'd30, 3, 0);
    next_cycle();
    @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
